ls_down_counter_chain: RTL
==========================

Name: ls_down_counter_chain

Overview:
- Synchronous cascadable down-counter (BCD-free binary), built from DIGITS 4-bit stages.
- It is the counting-down counterpart of the team's 4-bit up-counter. It provides:
  - parallel load,
  - ENP/ENT enables,
  - ripple borrow output for cascading,
  - optional auto-reload, so it can serve as a programmable interval timer.
- Sits beside the up-counter in the lab counter/timer library. It is intended for periodic tick generation and countdown timers.

Parameters:
- DIGITS, 2, number of cascaded 4-bit stages (1..8); counter width WIDTH = 4*DIGITS (derived localparam, not overridable).

Ports:
- CLK  in  1  clock; all state changes on rising edge
- CLR  in  1  synchronous, active-high reset
- D  in  WIDTH  parallel load value
- LOAD_n  in  1  active-low synchronous parallel load
- ENP  in  1  count enable parallel
- ENT  in  1  count enable trickle; also gates RBO
- RELOAD_EN  in  1  1: on terminal count, reload from captured value; 0: wrap to all-ones
- Q  out  WIDTH  counter value
- RBO  out  1  ripple borrow out, combinational: ENT & (Q == 0)
- ZERO  out  1  combinational: Q == 0, not gated by ENT
- DONE  out  1  registered one-cycle pulse on count-down arrival at zero

Behaviour:
- All sequential elements update only on rising CLK. Priority per edge: CLR > load (LOAD_n=0) > count (ENP&ENT=1) > hold.
- CLR=1: Q=0, internal reload register RLD=0, DONE=0. Reset applies the same mid-count, mid-load, or mid-DONE pulse, and DONE is cleared in the same edge.
- Reset-state outputs: Q=0, DONE=0, ZERO=1, RBO=ENT.
- Load: Q<=D, RLD<=D, DONE<=0. Load ignores ENP/ENT and RELOAD_EN. Loading 0 never raises DONE.
- Count (LOAD_n=1, ENP=1, ENT=1):
  - Q!=0: Q<=Q-1.
  - Q==0 and RELOAD_EN=1: Q<=RLD.
  - Q==0 and RELOAD_EN=0: Q<={WIDTH{1'b1}} (modulo-2^WIDTH wrap).
- DONE<=1 exactly when a count edge occurs with Q==1, so Q becomes 0. DONE<=0 on every other edge, including hold with Q==0. DONE therefore lags the Q==0 transition by zero cycles: it is registered alongside Q.
- Hold (ENP=0 or ENT=0, LOAD_n=1): Q and RLD unchanged; DONE<=0.
- RELOAD_EN is sampled only at the zero edge. RLD is written only by load or CLR.
- RLD=0 with RELOAD_EN=1: Q stays 0 while counting, and DONE never pulses, because Q never passes 1.
- Cascade structure:
  - Stage k enable = ENP & ENT & (stages 0..k-1 all zero).
  - Stage k borrows (decrements to 4'hF) when its lower stages are zero.
  - Auto-reload is applied to the full WIDTH word, not per stage.
- RBO/ZERO are purely combinational from Q and ENT, with no registered delay. External cascading of chains is done by tying RBO of the lower chain to ENT of the upper chain.
- No X-propagation is tolerated: every register has a defined reset value.

Decomposition:
- Shared package ls_counter_pkg:
  - DIGIT_W = 4
  - DIGIT_ZERO = 4'h0
  - DIGIT_MAX = 4'hF
- One sub-module, ls_down_stage (4-bit):
  - inputs: CLK, CLR, load, load data, count enable, wrap value
  - outputs: Q, zero flag
- The top level instantiates DIGITS stages via generate. It also holds RLD, the reload/wrap mux, and DONE.

Test Plan:
- DIGITS=2. CLR=1 for one edge with Q previously 8'h5A -> Q=8'h00, DONE=0, ZERO=1, RBO=ENT.
- Load D=8'h10 (LOAD_n=0, ENP=ENT=0), then count with ENP=ENT=1. The load edge sets Q=8'h10; subsequent edges give 8'h0F, 8'h0E …. This checks borrow across stages at 10->0F.
- Load 8'h03, RELOAD_EN=1, count continuously -> sequence 03, 02, 01, 00, 03, 02 …. DONE=1 only in the cycle Q=00 (once per period, period 4). RBO=1 in that same cycle.
- Load 8'h01, RELOAD_EN=0, count -> Q=00 with DONE=1, then FF with DONE=0, then FE. With ENT=0 at Q=00: RBO=0, ZERO=1, Q holds, DONE=0.
- Simultaneous events:
  - LOAD_n=0 and ENP=ENT=1 with D=8'h07 -> Q=07 (load wins).
  - CLR=1 and LOAD_n=0 -> Q=00 and RLD=00 (verified by a later RELOAD_EN=1 wrap giving 00).
- Reset mid-operation: assert CLR on the edge where Q goes 01->00. Required: Q=00, DONE=0, no pulse.

Source files
------------

// File: rtl/ls_counter_pkg.sv
// Shared constants and helpers for the lab counter/timer library.
// Digit-level definitions used by the cascadable 4-bit counter stages.
package ls_counter_pkg;

    localparam int         DIGIT_W    = 4;
    localparam logic [3:0] DIGIT_ZERO = 4'h0;
    localparam logic [3:0] DIGIT_MAX  = 4'hF;

    // Next value of a digit on a count-down step: borrow into wrap_value at zero.
    function automatic logic [DIGIT_W-1:0] digit_dec(
        input logic [DIGIT_W-1:0] value,
        input logic [DIGIT_W-1:0] wrap_value
    );
        if (value == DIGIT_ZERO)
            digit_dec = wrap_value;
        else
            digit_dec = value - 4'd1;
    endfunction

endpackage

// File: rtl/ls_down_stage.sv
// One 4-bit stage of the cascadable down-counter.
// The wrap value is supplied by the parent so that auto-reload can act on the full word.
module ls_down_stage
    import ls_counter_pkg::*;
(
    input  logic               CLK,
    input  logic               CLR,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_data,
    input  logic               count_en,
    input  logic [DIGIT_W-1:0] wrap_value,
    output logic [DIGIT_W-1:0] Q,
    output logic               zero
);

    always_ff @(posedge CLK) begin
        if (CLR)
            Q <= DIGIT_ZERO;
        else if (load)
            Q <= load_data;
        else if (count_en)
            Q <= digit_dec(Q, wrap_value);
    end

    assign zero = (Q == DIGIT_ZERO);

endmodule

// File: rtl/ls_down_counter_chain.sv
// Cascadable binary down-counter with parallel load, ENP/ENT enables,
// ripple borrow output and optional auto-reload from the last loaded value.
module ls_down_counter_chain
    import ls_counter_pkg::*;
#(
    parameter int DIGITS = 2
)(
    input  logic                      CLK,
    input  logic                      CLR,
    input  logic [DIGIT_W*DIGITS-1:0] D,
    input  logic                      LOAD_n,
    input  logic                      ENP,
    input  logic                      ENT,
    input  logic                      RELOAD_EN,
    output logic [DIGIT_W*DIGITS-1:0] Q,
    output logic                      RBO,
    output logic                      ZERO,
    output logic                      DONE
);

    localparam int WIDTH = DIGIT_W * DIGITS;

    logic [WIDTH-1:0]  rld;
    logic [WIDTH-1:0]  wrap_word;
    logic [DIGITS-1:0] stage_zero;
    logic [DIGITS-1:0] stage_en;
    logic              count_edge;
    logic              word_zero;
    logic              q_is_one;

    assign count_edge = LOAD_n & ENP & ENT;
    assign word_zero  = &stage_zero;
    assign q_is_one   = (Q == WIDTH'(1));

    // Only the all-zero word reloads; any other zero digit simply borrows to F.
    assign wrap_word = (word_zero && RELOAD_EN) ? rld : {WIDTH{1'b1}};

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_stage
            if (k == 0) begin : g_first
                assign stage_en[k] = count_edge;
            end else begin : g_upper
                assign stage_en[k] = count_edge & (&stage_zero[k-1:0]);
            end

            ls_down_stage u_stage (
                .CLK        (CLK),
                .CLR        (CLR),
                .load       (~LOAD_n),
                .load_data  (D[k*DIGIT_W +: DIGIT_W]),
                .count_en   (stage_en[k]),
                .wrap_value (wrap_word[k*DIGIT_W +: DIGIT_W]),
                .Q          (Q[k*DIGIT_W +: DIGIT_W]),
                .zero       (stage_zero[k])
            );
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (CLR)
            rld <= '0;
        else if (!LOAD_n)
            rld <= D;
    end

    // DONE marks the count step that lands on zero, registered alongside Q.
    always_ff @(posedge CLK) begin
        if (CLR)
            DONE <= 1'b0;
        else
            DONE <= count_edge & q_is_one;
    end

    assign ZERO = word_zero;
    assign RBO  = ENT & word_zero;

endmodule
